// File: rtl/can_pkg.sv
// Shared CAN bit-timing types: segment encoding and counter widths.
package can_pkg;

    localparam int SEG_W = 2;
    localparam int CNT_W = 5;

    typedef enum logic [SEG_W-1:0] {
        SEG_SYNC  = 2'd0,
        SEG_TSEG1 = 2'd1,
        SEG_TSEG2 = 2'd2
    } can_seg_e;

endpackage

// File: rtl/can_edge_det.sv
// Recessive-to-dominant edge qualifier evaluated at time-quantum resolution.
module can_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic tq_tick,
    input  logic rx,
    input  logic rx_bit,
    output logic fall_edge
);

    logic rx_tq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_tq <= 1'b1;
        end else if (tq_tick) begin
            rx_tq <= rx;
        end
    end

    // A dominant level after a recessive sample only counts while the last bit was recessive.
    assign fall_edge = tq_tick && rx_tq && !rx && rx_bit;

endmodule

// File: rtl/can_bit_sync.sv
// CAN bit timing: SYNC/TSEG1/TSEG2 sequencing, sampling, hard sync and resynchronisation.
module can_bit_sync
    import can_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             tq_tick,
    input  logic [3:0]       tseg1,
    input  logic [2:0]       tseg2,
    input  logic [1:0]       sjw,
    input  logic             rx,
    input  logic             hard_sync_en,
    output logic [SEG_W-1:0] seg,
    output logic             sample_point,
    output logic             bit_tick,
    output logic             rx_bit,
    output logic             resync_flag
);

    function automatic logic [CNT_W-1:0] sat_sub(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

    function automatic logic [CNT_W-1:0] min_u(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    can_seg_e         seg_q;
    logic [CNT_W-1:0] cnt, ext, shrink;
    logic [CNT_W-1:0] t1_len, t2_len, sjw_len;
    logic             resync_used;
    logic             fall_edge;

    logic [CNT_W-1:0] cnt_inc, ext_new, e_tseg2, l1_eff, l2_eff;
    logic             hsync, resync_ok, restart;

    can_edge_det u_edge (
        .clk       (clk),
        .rst       (rst),
        .tq_tick   (tq_tick),
        .rx        (rx),
        .rx_bit    (rx_bit),
        .fall_edge (fall_edge)
    );

    always_comb begin
        cnt_inc   = cnt + 5'd1;
        ext_new   = min_u(cnt_inc, sjw_len);
        e_tseg2   = sat_sub(t2_len, cnt);
        hsync     = fall_edge && hard_sync_en;
        resync_ok = fall_edge && !hard_sync_en && !resync_used && (seg_q != SEG_SYNC);
        // Lengths already reflect a resync applied on this same quantum.
        l1_eff    = t1_len + (((resync_ok && seg_q == SEG_TSEG1)) ? ext_new : ext);
        l2_eff    = (resync_ok && seg_q == SEG_TSEG2) ? sat_sub(t2_len, sjw_len)
                                                      : sat_sub(t2_len, shrink);
        restart   = hsync || (resync_ok && seg_q == SEG_TSEG2 && e_tseg2 <= sjw_len);
    end

    // Timing parameters are captured as a bit begins so mid-bit changes wait for the next bit.
    always_ff @(posedge clk) begin
        if (tq_tick && (seg_q == SEG_SYNC || restart)) begin
            t1_len  <= {1'b0, tseg1} + 5'd1;
            t2_len  <= {2'b00, tseg2} + 5'd1;
            sjw_len <= {3'b000, sjw} + 5'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q        <= SEG_SYNC;
            cnt          <= '0;
            ext          <= '0;
            shrink       <= '0;
            rx_bit       <= 1'b1;
            resync_used  <= 1'b0;
            sample_point <= 1'b0;
            bit_tick     <= 1'b0;
            resync_flag  <= 1'b0;
        end else begin
            sample_point <= 1'b0;
            bit_tick     <= 1'b0;
            resync_flag  <= 1'b0;
            if (tq_tick) begin
                if (restart) begin
                    seg_q       <= SEG_TSEG1;
                    cnt         <= '0;
                    ext         <= '0;
                    shrink      <= '0;
                    bit_tick    <= 1'b1;
                    resync_flag <= 1'b1;
                    resync_used <= 1'b1;
                end else begin
                    case (seg_q)
                        SEG_SYNC: begin
                            seg_q <= SEG_TSEG1;
                            cnt   <= '0;
                        end
                        SEG_TSEG1: begin
                            if (resync_ok) begin
                                ext         <= ext_new;
                                resync_flag <= 1'b1;
                                resync_used <= 1'b1;
                            end
                            if (cnt_inc >= l1_eff) begin
                                rx_bit       <= rx;
                                sample_point <= 1'b1;
                                resync_used  <= 1'b0;
                                seg_q        <= SEG_TSEG2;
                                cnt          <= '0;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end
                        SEG_TSEG2: begin
                            if (resync_ok) begin
                                shrink      <= sjw_len;
                                resync_flag <= 1'b1;
                                resync_used <= 1'b1;
                            end
                            if (cnt_inc >= l2_eff) begin
                                seg_q    <= SEG_SYNC;
                                cnt      <= '0;
                                ext      <= '0;
                                shrink   <= '0;
                                bit_tick <= 1'b1;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end
                        default: begin
                            seg_q <= SEG_SYNC;
                            cnt   <= '0;
                        end
                    endcase
                end
            end
        end
    end

    assign seg = seg_q;

endmodule

// File: tb/tb_can_bit_sync.sv
// Directed bench for can_bit_sync with tseg1=5, tseg2=2, sjw=1 (6/3/2 TQ, 10 TQ nominal bit).
module tb_can_bit_sync;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tq_tick = 1'b0;
    logic [3:0] tseg1 = 4'd5;
    logic [2:0] tseg2 = 3'd2;
    logic [1:0] sjw = 2'd1;
    logic       rx = 1'b1;
    logic       hard_sync_en = 1'b0;
    logic [1:0] seg;
    logic       sample_point, bit_tick, rx_bit, resync_flag;

    int checks = 0;
    int failures = 0;
    int len, sp_at, rf_cnt;

    can_bit_sync dut (
        .clk          (clk),
        .rst          (rst),
        .tq_tick      (tq_tick),
        .tseg1        (tseg1),
        .tseg2        (tseg2),
        .sjw          (sjw),
        .rx           (rx),
        .hard_sync_en (hard_sync_en),
        .seg          (seg),
        .sample_point (sample_point),
        .bit_tick     (bit_tick),
        .rx_bit       (rx_bit),
        .resync_flag  (resync_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One quantum: tick high for exactly one posedge, outputs observed at the following negedge.
    task automatic tq();
        @(negedge clk);
        tq_tick = 1'b1;
        @(negedge clk);
        tq_tick = 1'b0;
    endtask

    // Runs quanta until bit_tick; bit k of low_mask drives rx dominant on quantum k.
    task automatic run_bit(input logic [39:0] low_mask, input logic hs,
                           output int n, output int sp, output int rf);
        n = 0; sp = 0; rf = 0;
        hard_sync_en = hs;
        for (int k = 1; k < 40; k++) begin
            rx = low_mask[k] ? 1'b0 : 1'b1;
            tq();
            if (sample_point && sp == 0) sp = k;
            if (resync_flag) rf++;
            if (bit_tick) begin
                n = k;
                break;
            end
        end
        rx = 1'b1;
        hard_sync_en = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_seg", seg, 0);
        chk("reset_rx_bit", rx_bit, 1);
        chk("reset_pulses", {sample_point, bit_tick, resync_flag}, 0);
        rst = 1'b0;
        @(negedge clk);

        tq();
        chk("first_tick_seg", seg, 1);
        chk("first_tick_no_bit_tick", bit_tick, 0);
        run_bit(40'd0, 1'b0, len, sp_at, rf_cnt);
        chk("first_bit_len", len, 9);

        // Nominal bit, and pulses are single-clock with state held between ticks
        run_bit(40'd0, 1'b0, len, sp_at, rf_cnt);
        chk("nominal_len", len, 10);
        chk("nominal_sp", sp_at, 7);
        chk("nominal_rf", rf_cnt, 0);
        chk("nominal_rx_bit", rx_bit, 1);
        @(negedge clk);
        chk("pulse_one_clk", bit_tick, 0);
        chk("hold_seg_sync", seg, 0);

        // Hard sync at TSEG2 cnt=1
        run_bit(40'd1 << 9, 1'b1, len, sp_at, rf_cnt);
        chk("hsync_len", len, 9);
        chk("hsync_rf", rf_cnt, 1);
        run_bit(40'd0, 1'b0, len, sp_at, rf_cnt);
        chk("after_hsync_len", len, 9);
        chk("after_hsync_sp", sp_at, 6);

        // TSEG1 resync at cnt=0 and cnt=4
        run_bit(40'd1 << 2, 1'b0, len, sp_at, rf_cnt);
        chk("t1c0_len", len, 11);
        chk("t1c0_sp", sp_at, 8);
        chk("t1c0_rf", rf_cnt, 1);
        run_bit(40'd0, 1'b0, len, sp_at, rf_cnt);
        chk("ext_cleared_len", len, 10);
        run_bit(40'd1 << 6, 1'b0, len, sp_at, rf_cnt);
        chk("t1c4_len", len, 12);
        chk("t1c4_sp", sp_at, 9);

        // TSEG2 resync: large phase error shrinks, small one restarts
        run_bit(40'd1 << 8, 1'b0, len, sp_at, rf_cnt);
        chk("t2c0_len", len, 8);
        chk("t2c0_rf", rf_cnt, 1);
        run_bit(40'd0, 1'b0, len, sp_at, rf_cnt);
        chk("shrink_cleared_len", len, 10);
        run_bit(40'd1 << 10, 1'b0, len, sp_at, rf_cnt);
        chk("t2c2_len", len, 10);
        chk("t2c2_rf", rf_cnt, 1);
        run_bit(40'd0, 1'b0, len, sp_at, rf_cnt);
        chk("after_t2c2_len", len, 9);
        chk("after_t2c2_sp", sp_at, 6);

        // Second edge within one bit is ignored
        run_bit((40'd1 << 3) | (40'd1 << 5), 1'b0, len, sp_at, rf_cnt);
        chk("two_edges_len", len, 12);
        chk("two_edges_rf", rf_cnt, 1);

        // Dominant sampled bit, then a falling level while rx_bit=0 is not an edge
        run_bit(40'h3FC, 1'b0, len, sp_at, rf_cnt);
        chk("dom_len", len, 11);
        chk("dom_rx_bit", rx_bit, 0);
        run_bit(40'd1 << 3, 1'b0, len, sp_at, rf_cnt);
        chk("rxbit0_len", len, 10);
        chk("rxbit0_rf", rf_cnt, 0);
        chk("rxbit0_sp", sp_at, 7);
        chk("rxbit0_rx_bit", rx_bit, 1);

        // Reset in TSEG1 cnt=3
        repeat (4) tq();
        chk("pre_reset_seg", seg, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_reset_seg", seg, 0);
        chk("mid_reset_rx_bit", rx_bit, 1);
        chk("mid_reset_pulses", {sample_point, bit_tick, resync_flag}, 0);
        @(negedge clk);
        rst = 1'b0;
        tq();
        chk("post_reset_seg", seg, 1);
        chk("post_reset_no_bit_tick", bit_tick, 0);
        run_bit(40'd0, 1'b0, len, sp_at, rf_cnt);
        chk("post_reset_len", len, 9);
        chk("post_reset_sp", sp_at, 6);
        chk("post_reset_rf", rf_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
